// File: rtl/ssd_driver.sv
// 13-bit binary to 4-digit BCD (sequential double-dabble) driving a multiplexed common-anode display.
// Optional leading-zero blanking when SSD_LZ_BLANK_EN is defined.
module ssd_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value_i,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o,
    output logic [15:0] bcd_o,
    output logic        conv_done_o
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {StSample, StShift, StCommit} state_e;

    state_e          state_q, state_d;
    logic [12:0]     bin_q, bin_d;
    logic [15:0]     scr_q, scr_d;
    logic [15:0]     scr_adj;
    logic [3:0]      iter_q, iter_d;
    logic [15:0]     bcd_q, bcd_d;
    logic            done_q, done_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic [3:0]      nib;
    logic [3:0]      nib_zero;
    logic            lz_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Converter: SAMPLE, 13 x SHIFT, COMMIT -> 15-cycle period
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        scr_adj = scr_q;
        for (int i = 0; i < 4; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        unique case (state_q)
            StSample: begin
                bin_d   = value_i;
                scr_d   = 16'd0;
                iter_d  = 4'd0;
                state_d = StShift;
            end
            StShift: begin
                {scr_d, bin_d} = {scr_adj[14:0], bin_q, 1'b0};
                iter_d         = iter_q + 4'd1;
                if (iter_q == 4'd12) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                bcd_d   = scr_q;
                done_d  = 1'b1;
                state_d = StSample;
            end
            default: state_d = StSample;
        endcase
    end

    // Scan: anode and segments are registered from next-state values so they move together
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        for (int i = 0; i < 4; i++) begin
            nib_zero[i] = (bcd_d[4*i +: 4] == 4'd0);
        end
`ifdef SSD_LZ_BLANK_EN
        unique case (idx_d)
            2'd3:    lz_blank = nib_zero[3];
            2'd2:    lz_blank = nib_zero[3] & nib_zero[2];
            2'd1:    lz_blank = &nib_zero[3:1];
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif
        nib   = bcd_d[{idx_d, 2'b00} +: 4];
        an_d  = ~(4'b0001 << idx_d);
        seg_d = lz_blank ? 7'b1111111 : seg_decode(nib);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StSample;
            bin_q   <= '0;
            scr_q   <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 7'b1000000;
            an_q    <= 4'b1110;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bcd_o       = bcd_q;
    assign conv_done_o = done_q;
    assign seg_o       = seg_q;
    assign an_o        = an_q;

endmodule

// File: tb/tb_ssd_driver.sv
// Bench for ssd_driver: decimal-arithmetic model checked every cycle plus directed literal checks.
module tb_ssd_driver;

    localparam int Div = 4;

    logic        clk;
    logic        rst;
    logic [12:0] value_i;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;
    logic [15:0] bcd_o;
    logic        conv_done_o;

    int tests = 0;
    int fails = 0;

    ssd_driver #(.REFRESH_DIV(Div)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_i    (value_i),
        .seg_o      (seg_o),
        .an_o       (an_o),
        .bcd_o      (bcd_o),
        .conv_done_o(conv_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int pow10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b;
        for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return b;
    endfunction

    // Model: cycle n (edges since reset) samples on n%15==1, commits on n%15==0
    int          n;
    int          pend;
    int          mval;
    logic        mdone;
    initial begin
        int          idx;
        logic [3:0]  ean;
        logic [6:0]  eseg;
        logic        blank;
        n = 0; pend = 0; mval = 0; mdone = 1'b0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                n = 0; mval = 0; mdone = 1'b0;
            end else begin
                n++;
                mdone = 1'b0;
                if (n % 15 == 1) pend = int'(value_i);
                if (n % 15 == 0) begin
                    mval  = pend;
                    mdone = 1'b1;
                end
                idx  = (n / Div) % 4;
                ean  = 4'hF ^ (4'b0001 << idx);
`ifdef SSD_LZ_BLANK_EN
                blank = (idx > 0) && (mval < pow10(idx));
`else
                blank = 1'b0;
`endif
                eseg = blank ? 7'b1111111 : glyph((mval / pow10(idx)) % 10);
                #1;
                check("model_bcd", 32'(bcd_o), 32'(to_bcd(mval)));
                check("model_done", 32'(conv_done_o), 32'(mdone));
                check("model_an", 32'(an_o), 32'(ean));
                check("model_seg", 32'(seg_o), 32'(eseg));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string name, output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (!conv_done_o && k < 60);
        if (!conv_done_o) begin
            tests++; fails++;
            $display("FAIL %s: conv_done_o timeout, got 0, expected 1", name);
        end
    endtask

    task automatic wait_an(input string name, input logic [3:0] exp);
        int b = 0;
        while (an_o !== exp && b < 40) begin
            step();
            b++;
        end
        check(name, 32'(an_o), 32'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 32'(an_o), 32'(4'b1110));
        check({tag, "_seg"}, 32'(seg_o), 32'(7'b1000000));
        check({tag, "_bcd"}, 32'(bcd_o), 32'h0000);
        check({tag, "_done"}, 32'(conv_done_o), 32'(1'b0));
    endtask

    task automatic wait_value(input string name, input logic [12:0] v, input logic [15:0] exp);
        int k = 0;
        @(negedge clk);
        value_i = v;
        do begin
            step();
            k++;
        end while (!(conv_done_o && bcd_o == exp) && k < 40);
        check({name, "_bcd"}, 32'(bcd_o), 32'(exp));
        check({name, "_lat"}, 32'(k <= 29), 32'd1);
    endtask

    initial begin
        int         k;
        logic [3:0] ans  [4];
        logic [6:0] segs [4];
        ans[0] = 4'b1110; ans[1] = 4'b1101; ans[2] = 4'b1011; ans[3] = 4'b0111;
        segs[0] = 7'b0011001; segs[1] = 7'b0110000; segs[2] = 7'b0100100; segs[3] = 7'b1111001;

        rst = 1'b0;
        value_i = 13'd1234;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        @(negedge clk);
        rst = 1'b1;
        wait_done("first_conv", k);
        check("first_done_cycle", 32'(k), 32'd15);
        check("first_bcd", 32'(bcd_o), 32'h1234);

        // Scan: each digit lit for Div cycles with the 1234 glyphs, then wrap
        for (int d = 0; d < 4; d++) begin
            wait_an("scan_an", ans[d]);
            check("scan_seg", 32'(seg_o), 32'(segs[d]));
            k = 0;
            do begin
                step();
                k++;
            end while (an_o == ans[d] && k < 12);
            check("scan_hold", 32'(k), 32'(Div));
        end
        check("scan_wrap", 32'(an_o), 32'(4'b1110));

        wait_value("max", 13'd8191, 16'h8191);
        wait_value("zero", 13'd0, 16'h0000);
        wait_value("nine", 13'd9, 16'h0009);
        wait_done("period_a", k);
        wait_done("period_b", k);
        check("done_period", 32'(k), 32'd15);

        wait_value("seven", 13'd7, 16'h0007);
        wait_an("blank_an3", 4'b0111);
`ifdef SSD_LZ_BLANK_EN
        check("blank_seg3", 32'(seg_o), 32'(7'b1111111));
`else
        check("blank_seg3", 32'(seg_o), 32'(7'b1000000));
`endif
        wait_an("blank_an0", 4'b1110);
        check("blank_seg0", 32'(seg_o), 32'(7'b1111000));

        // Mid-conversion change: 42 arrives at the 5th SHIFT cycle
        @(negedge clk);
        value_i = 13'd100;
        wait_done("mid_sync", k);
        repeat (6) @(negedge clk);
        value_i = 13'd42;
        wait_done("mid_a", k);
        check("mid_first", 32'(bcd_o), 32'h0100);
        wait_done("mid_b", k);
        check("mid_second", 32'(bcd_o), 32'h0042);

        // Asynchronous reset during SHIFT
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        wait_done("restart", k);
        check("restart_cycle", 32'(k), 32'd15);
        check("restart_bcd", 32'(bcd_o), 32'h0042);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ssd_driver.md
# ssd_driver

Consumer end of the CPU's 13-bit `ssd_o` debug bus. It converts the binary value to four BCD digits using a sequential double-dabble converter. It then time-multiplexes those digits onto a 4-digit common-anode seven-segment display. It sits between the CPU top level and the board pins, alongside the LED selector logic.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit is lit. Must be at least 2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `value_i`  in  13  unsigned binary value to display, range 0..8191.
- `seg_o`  out  7  segment cathodes, active-low. Bit 0 is segment a, bit 6 is segment g.
- `an_o`  out  4  digit anodes, active-low, one-hot. Bit 0 is the units digit.
- `bcd_o`  out  16  committed BCD value. Bits [15:12] are thousands; bits [3:0] are units.
- `conv_done_o`  out  1  one-cycle pulse in the cycle `bcd_o` updates.

## Operation
- Converter FSM, free-running, 15-cycle period:
  - SAMPLE (1 cycle): latch `value_i` into the shift register and clear the BCD scratch.
  - SHIFT (13 cycles): each cycle, add 3 to every scratch nibble that is ≥5, then shift {scratch, binary} left by 1.
  - COMMIT (1 cycle): copy the scratch to `bcd_o` and assert `conv_done_o`.
  - COMMIT returns to SAMPLE.
- Conversion width:
  - The scratch is 16 bits. 8191 is the maximum, so the thousands nibble never exceeds 8.
  - An iteration counter of 4 bits counts 0..12.
- `value_i` is sampled only in SAMPLE. Changes during SHIFT or COMMIT are ignored until the next SAMPLE.
- Scan logic:
  - The refresh counter counts 0..`REFRESH_DIV`-1.
  - At terminal count the counter wraps to 0 and the 2-bit digit index increments, wrapping 3→0.
  - `an_o` = ~(1 << index).
  - `seg_o` = decode of the `bcd_o` nibble selected by index.
- Decode, active-low gfedcba:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other nibble = 1111111 (blank). This cannot occur in normal operation.
- The scan and the converter are independent. A digit may change value while lit, in the cycle after COMMIT.

## Timing
- Reset values:
  - FSM in SAMPLE; refresh counter 0; index 0.
  - `bcd_o` = 0, `conv_done_o` = 0.
  - `an_o` = 1110, `seg_o` = 1000000.
- After `rst` deasserts, the first SAMPLE occurs on the first rising edge and the first `conv_done_o` on cycle 15.
- Latency from `value_i` stable to `bcd_o` valid is at most 29 cycles (worst case: just missed SAMPLE).
- `seg_o` and `an_o` are registered and change in the same cycle: the cycle after the refresh counter wraps, or the cycle after COMMIT for `seg_o`. There is no cycle where two anodes are active.
- Reset asserted mid-conversion or mid-scan forces all reset values immediately. The partial conversion is discarded.

## Configuration
- `SSD_LZ_BLANK_EN` defined: leading-zero blanking.
  - A digit shows 1111111 if it and all higher digits are 0.
  - The units digit is never blanked.
  - Blanking is computed from the committed `bcd_o`.
- Not defined: all four digits are always displayed, including leading zeros.
- `bcd_o` and `conv_done_o` are unaffected by the macro.

## Test plan
- Reset: hold `rst` low with `value_i` = 1234 → `an_o` = 1110, `seg_o` = 1000000, `bcd_o` = 0000, `conv_done_o` = 0. After release, the first `conv_done_o` arrives at cycle 15 with `bcd_o` = 16'h1234.
- Boundaries: `value_i` = 8191, then 0, then 9 → `bcd_o` = 16'h8191, then 16'h0000, then 16'h0009, each within 29 cycles. `conv_done_o` pulses exactly every 15 cycles.
- Scan with `REFRESH_DIV` = 4 and `value_i` = 1234 → `an_o` cycles 1110/1101/1011/0111, 4 cycles each, with `seg_o` = 0011001/0110000/0100100/1111001. It wraps back to 1110.
- Blanking with `value_i` = 7:
  - With `SSD_LZ_BLANK_EN`: digits 3..1 show `seg_o` = 1111111 and digit 0 shows 1111000.
  - Without the macro: digits 3..1 show 1000000.
- Mid-conversion change: `value_i` = 100, switched to 42 at the 5th SHIFT cycle → that COMMIT gives `bcd_o` = 16'h0100 and the next gives 16'h0042.
- Reset mid-conversion: assert `rst` during SHIFT → outputs take their reset values asynchronously, before the next clock edge. After release, a full 15-cycle conversion restarts from SAMPLE.
